fifo_canal: RTL and testbench

Per-channel synchronous FIFO that sits directly downstream of the 1-to-4 demux. One instance per demux output, salida0..salida3. Each instance buffers the words steered to its channel and presents them to the channel consumer through a pop interface. It also exposes occupancy flags with programmable almost-full and almost-empty thresholds, which upstream flow control uses to gate the demux enable.

---
 rtl/fifo_canal_pkg.sv | 40 ++++
 rtl/memoria_fifo.sv | 60 ++++++
 rtl/fifo_canal.sv | 142 ++++++++++++++
 tb/tb_fifo_canal.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_canal_pkg.sv
//------------------------------------------------------------------------------
//  fifo_canal_pkg
//  Shared definitions for the per-channel FIFO bank. The guarded macro block
//  holds the defaults shared with the 1-to-4 demux and the fifo bank wrapper.
//  The package exposes them as typed localparams, together with the encoding
//  of the operation accepted on each edge.
//  Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef FIFO_CANAL_DEFS
`define FIFO_CANAL_DEFS
`define FIFO_CANAL_DATA_BITS 4
`define FIFO_CANAL_DEPTH     8
`define FIFO_NUM_CANALES     4
`endif

package fifo_canal_pkg;

  // Defaults shared with the demux (DATA_BITS) and the bank wrapper.
  localparam int unsigned C_DATA_BITS_DEF = `FIFO_CANAL_DATA_BITS;
  localparam int unsigned C_DEPTH_DEF     = `FIFO_CANAL_DEPTH;
  localparam int unsigned C_NUM_CANALES   = `FIFO_NUM_CANALES;

  // Operation accepted on a given edge, encoded as {pop_ok, push_ok}.
  typedef enum logic [1:0] {
    OP_NADA  = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_AMBOS = 2'b11
  } op_e;

  // DEPTH must be a power of two so that pointers wrap naturally.
  function automatic bit es_pot2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memoria_fifo.sv
//------------------------------------------------------------------------------
//  memoria_fifo
//  DEPTH x DATA_BITS storage for one FIFO channel. It has one synchronous
//  write port and one registered read port. The array itself is not reset.
//  Only the read data register is cleared, so that the FIFO output reads 0
//  right after reset.
//
//  Ports:
//    clk      - clock, rising edge
//    reset    - asynchronous active-high reset (read register only)
//    we_i     - write enable
//    waddr_i  - write address
//    wdata_i  - write data
//    re_i     - read enable; loads rdata_o on the edge
//    raddr_i  - read address
//    rdata_o  - registered read data (holds when re_i is low)
//  Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memoria_fifo #(
  parameter int DATA_BITS = 4,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  // Storage array: no reset, plain write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read and a write to the same address on one edge return the old
  // contents. The full push+pop case depends on this.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fifo_canal.sv
//------------------------------------------------------------------------------
//  fifo_canal
//  Synchronous FIFO for one demux output channel. It holds the read and
//  write pointers, the occupancy count, the status flags and the sticky
//  error flag. Storage is in memoria_fifo.
//
//  Ports:
//    clk          - clock, rising edge
//    reset        - asynchronous active-high reset
//    push         - write strobe
//    entrada      - write data
//    pop          - read request
//    umbral_alto  - almost-full threshold (conteo >= umbral_alto)
//    umbral_bajo  - almost-empty threshold (conteo <= umbral_bajo)
//    salida       - registered read data, one cycle after an accepted pop
//    valido       - salida holds a word popped on the previous edge
//    conteo       - occupancy, 0..DEPTH
//    lleno/vacio  - full / empty
//    casi_lleno   - almost full
//    casi_vacio   - almost empty
//    error        - sticky overflow/underflow
//  Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_canal
  import fifo_canal_pkg::*;
#(
  parameter int DATA_BITS = C_DATA_BITS_DEF,
  parameter int DEPTH     = C_DEPTH_DEF,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] entrada,
  input  logic                 pop,
  input  logic [ADDR_BITS:0]   umbral_alto,
  input  logic [ADDR_BITS:0]   umbral_bajo,
  output logic [DATA_BITS-1:0] salida,
  output logic                 valido,
  output logic [ADDR_BITS:0]   conteo,
  output logic                 lleno,
  output logic                 vacio,
  output logic                 casi_lleno,
  output logic                 casi_vacio,
  output logic                 error
);

  localparam logic [ADDR_BITS:0]   C_CNT_DEPTH = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   C_CNT_UNO   = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] C_PTR_UNO   = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   conteo_q, conteo_d;
  logic                 valido_q, valido_d;
  logic                 error_q,  error_d;

  logic                 lleno_w;
  logic                 vacio_w;
  logic                 push_ok;
  logic                 pop_ok;
  op_e                  op;

  // Flags come straight from the registered count. They carry no extra latency.
  assign lleno_w = (conteo_q == C_CNT_DEPTH);
  assign vacio_w = (conteo_q == '0);

  // A pop is possible whenever data is present. A push into a full FIFO is
  // still accepted when the pop frees a slot on the same edge. There is no
  // empty bypass: a pop on an empty FIFO is rejected even when a push
  // happens at the same time.
  assign pop_ok  = pop  && !vacio_w;
  assign push_ok = push && (!lleno_w || pop_ok);
  assign op      = op_e'({pop_ok, push_ok});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    conteo_d = conteo_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + C_PTR_UNO;   // wraps modulo DEPTH (power of two)
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + C_PTR_UNO;
    end

    // Occupancy is tracked only here. The pointers are never compared.
    case (op)
      OP_PUSH: conteo_d = conteo_q + C_CNT_UNO;
      OP_POP:  conteo_d = conteo_q - C_CNT_UNO;
      default: conteo_d = conteo_q;
    endcase

    valido_d = pop_ok;
    error_d  = error_q || (push && !push_ok) || (pop && !pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      conteo_q <= '0;
      valido_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      conteo_q <= conteo_d;
      valido_q <= valido_d;
      error_q  <= error_d;
    end
  end

  memoria_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_memoria (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (entrada),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (salida)
  );

  assign valido     = valido_q;
  assign conteo     = conteo_q;
  assign lleno      = lleno_w;
  assign vacio      = vacio_w;
  assign casi_lleno = (conteo_q >= umbral_alto);
  assign casi_vacio = (conteo_q <= umbral_bajo);
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_canal.sv
//------------------------------------------------------------------------------
//  tb_fifo_canal
//  Directed bench for fifo_canal (DATA_BITS=4, DEPTH=8). A vector table
//  covers ordered data, thresholds and push+pop in mid-occupancy.
//  Hand-written sequences cover async reset, overflow, the full and empty
//  corner cases, and combinational threshold changes.
//  Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_canal;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [3:0] entrada;
  logic       pop;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [3:0] salida;
  logic       valido;
  logic [3:0] conteo;
  logic       lleno, vacio, casi_lleno, casi_vacio, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_canal #(.DATA_BITS(4), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .entrada     (entrada),
    .pop         (pop),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .salida      (salida),
    .valido      (valido),
    .conteo      (conteo),
    .lleno       (lleno),
    .vacio       (vacio),
    .casi_lleno  (casi_lleno),
    .casi_vacio  (casi_vacio),
    .error       (error)
  );

  typedef struct {
    logic       ps;
    logic       pp;
    logic [3:0] din;
    logic [3:0] e_cnt;
    logic [3:0] e_sal;
    logic       e_val;
    logic       e_ll;
    logic       e_va;
    logic       e_cl;
    logic       e_cv;
  } vec_t;

  vec_t tabla [20];

  function automatic vec_t v(input logic ps, input logic pp, input logic [3:0] din,
                             input logic [3:0] e_cnt, input logic [3:0] e_sal,
                             input logic e_val, input logic e_ll, input logic e_va,
                             input logic e_cl, input logic e_cv);
    vec_t r;
    r.ps = ps; r.pp = pp; r.din = din; r.e_cnt = e_cnt; r.e_sal = e_sal;
    r.e_val = e_val; r.e_ll = e_ll; r.e_va = e_va; r.e_cl = e_cl; r.e_cv = e_cv;
    return r;
  endfunction

  task automatic chk(input string nombre, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, got, exp, $time);
    end
  endtask

  // Drive one edge's worth of stimulus and return 1 time unit after the edge.
  task automatic paso(input logic ps, input logic pp, input logic [3:0] d);
    push = ps; pop = pp; entrada = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic aplicar_reset();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; entrada = 4'h0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;

    //            ps    pp    din    cnt    sal    val   ll    va    cl    cv
    tabla[0]  = v(1'b1, 1'b0, 4'h1, 4'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[1]  = v(1'b1, 1'b0, 4'h2, 4'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[2]  = v(1'b1, 1'b0, 4'h3, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[3]  = v(1'b0, 1'b1, 4'h0, 4'd2, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[4]  = v(1'b0, 1'b1, 4'h0, 4'd1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[5]  = v(1'b0, 1'b1, 4'h0, 4'd0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tabla[6]  = v(1'b0, 1'b0, 4'h0, 4'd0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tabla[7]  = v(1'b1, 1'b0, 4'h4, 4'd1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[8]  = v(1'b1, 1'b0, 4'h5, 4'd2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[9]  = v(1'b1, 1'b0, 4'h6, 4'd3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[10] = v(1'b1, 1'b0, 4'h7, 4'd4, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[11] = v(1'b1, 1'b0, 4'h8, 4'd5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[12] = v(1'b1, 1'b0, 4'h9, 4'd6, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tabla[13] = v(1'b1, 1'b0, 4'hA, 4'd7, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tabla[14] = v(1'b0, 1'b1, 4'h0, 4'd6, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tabla[15] = v(1'b0, 1'b1, 4'h0, 4'd5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[16] = v(1'b0, 1'b1, 4'h0, 4'd4, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[17] = v(1'b0, 1'b1, 4'h0, 4'd3, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tabla[18] = v(1'b0, 1'b1, 4'h0, 4'd2, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tabla[19] = v(1'b1, 1'b1, 4'hB, 4'd2, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_conteo", 8'(conteo), 8'd0);
    chk("rst_vacio", 8'(vacio), 8'd1);
    chk("rst_lleno", 8'(lleno), 8'd0);
    chk("rst_casi_vacio", 8'(casi_vacio), 8'd1);
    chk("rst_casi_lleno", 8'(casi_lleno), 8'd0);
    chk("rst_salida", 8'(salida), 8'd0);
    chk("rst_valido", 8'(valido), 8'd0);
    chk("rst_error", 8'(error), 8'd0);

    // Table: ordered data, thresholds, mid-occupancy push+pop
    for (int i = 0; i < 20; i++) begin
      paso(tabla[i].ps, tabla[i].pp, tabla[i].din);
      chk($sformatf("vec%0d_conteo", i), 8'(conteo), 8'(tabla[i].e_cnt));
      chk($sformatf("vec%0d_salida", i), 8'(salida), 8'(tabla[i].e_sal));
      chk($sformatf("vec%0d_valido", i), 8'(valido), 8'(tabla[i].e_val));
      chk($sformatf("vec%0d_lleno", i), 8'(lleno), 8'(tabla[i].e_ll));
      chk($sformatf("vec%0d_vacio", i), 8'(vacio), 8'(tabla[i].e_va));
      chk($sformatf("vec%0d_casi_lleno", i), 8'(casi_lleno), 8'(tabla[i].e_cl));
      chk($sformatf("vec%0d_casi_vacio", i), 8'(casi_vacio), 8'(tabla[i].e_cv));
      chk($sformatf("vec%0d_error", i), 8'(error), 8'd0);
    end

    // Queue holds A,B. Add C,D, pop A (3 words remain, valido=1).
    paso(1'b1, 1'b0, 4'hC);
    paso(1'b1, 1'b0, 4'hD);
    paso(1'b0, 1'b1, 4'h0);
    chk("pre_rst_salida", 8'(salida), 8'hA);
    chk("pre_rst_conteo", 8'(conteo), 8'd3);
    // Async reset mid-cycle: outputs must clear with no clock edge.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_conteo", 8'(conteo), 8'd0);
    chk("async_rst_vacio", 8'(vacio), 8'd1);
    chk("async_rst_valido", 8'(valido), 8'd0);
    chk("async_rst_salida", 8'(salida), 8'd0);
    chk("async_rst_error", 8'(error), 8'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Fill and overflow
    for (int i = 0; i < 9; i++) begin
      paso(1'b1, 1'b0, 4'(i));
      if (i == 7) begin
        chk("fill8_lleno", 8'(lleno), 8'd1);
        chk("fill8_conteo", 8'(conteo), 8'd8);
        chk("fill8_error", 8'(error), 8'd0);
      end
    end
    chk("ovf_conteo", 8'(conteo), 8'd8);
    chk("ovf_error", 8'(error), 8'd1);
    for (int i = 0; i < 8; i++) begin
      paso(1'b0, 1'b1, 4'h0);
      chk($sformatf("drain%0d_salida", i), 8'(salida), 8'(i));
      chk($sformatf("drain%0d_valido", i), 8'(valido), 8'd1);
    end
    chk("drain_conteo", 8'(conteo), 8'd0);
    chk("drain_vacio", 8'(vacio), 8'd1);

    // Full push+pop
    aplicar_reset();
    for (int i = 0; i < 8; i++) paso(1'b1, 1'b0, 4'(i + 1));
    paso(1'b1, 1'b1, 4'hA);
    chk("fullpp_salida", 8'(salida), 8'h1);
    chk("fullpp_conteo", 8'(conteo), 8'd8);
    chk("fullpp_error", 8'(error), 8'd0);
    chk("fullpp_lleno", 8'(lleno), 8'd1);
    for (int i = 0; i < 8; i++) begin
      paso(1'b0, 1'b1, 4'h0);
      chk($sformatf("fulldrain%0d", i), 8'(salida), (i == 7) ? 8'hA : 8'(i + 2));
    end
    chk("fulldrain_error", 8'(error), 8'd0);

    // Empty underflow
    paso(1'b0, 1'b1, 4'h0);
    chk("udf_error", 8'(error), 8'd1);
    chk("udf_valido", 8'(valido), 8'd0);
    chk("udf_conteo", 8'(conteo), 8'd0);
    chk("udf_salida_hold", 8'(salida), 8'hA);

    // Empty push+pop: push accepted, pop rejected
    aplicar_reset();
    chk("rst2_error", 8'(error), 8'd0);
    paso(1'b1, 1'b1, 4'h5);
    chk("emptypp_conteo", 8'(conteo), 8'd1);
    chk("emptypp_valido", 8'(valido), 8'd0);
    chk("emptypp_error", 8'(error), 8'd1);

    // Thresholds act combinationally
    umbral_alto = 4'd1;
    #1 chk("umbral_alto_comb", 8'(casi_lleno), 8'd1);
    umbral_bajo = 4'd0;
    #1 chk("umbral_bajo_comb", 8'(casi_vacio), 8'd0);
    umbral_alto = 4'd6; umbral_bajo = 4'd2;

    paso(1'b0, 1'b1, 4'h0);
    chk("emptypp_pop_salida", 8'(salida), 8'h5);
    chk("emptypp_pop_valido", 8'(valido), 8'd1);
    chk("emptypp_pop_conteo", 8'(conteo), 8'd0);
    paso(1'b0, 1'b0, 4'h0);
    chk("idle_valido", 8'(valido), 8'd0);
    chk("idle_salida_hold", 8'(salida), 8'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
